// File: rtl/neuron_sequencer.sv
// neuron_sequencer: control sequencer for one neuron MAC datapath.
// Clears the accumulator, streams N input/weight pairs from a synchronous-read
// operand memory into the datapath, captures the activation result and offers
// it on a valid/ready handshake.
// Optional feature macro: NEURON_BIAS_EN (appends a bias load, +1 x bias_w,
// after the N operand loads).
module neuron_sequencer #(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_in,
    input  logic [7:0]    rd_w,
    output logic          dp_clr,
    output logic          dp_ld,
    output logic [15:0]   dp_idx,
    output logic [7:0]    dp_in,
    output logic [7:0]    dp_w,
    input  logic [15:0]   dp_res,
    input  logic [7:0]    bias_w,
    output logic [15:0]   result,
    output logic          result_valid,
    input  logic          result_ready
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        CAPTURE,
        OUT
    } state_t;

    localparam logic [AW-1:0] K_LAST = AW'(N - 1);
`ifdef NEURON_BIAS_EN
    localparam logic [AW-1:0] K_BIAS = AW'(N);
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic          busy_q, busy_d;
    logic          rd_en_q, rd_en_d;
    logic          clr_q, clr_d;
    logic          ld_q, ld_d;
    logic          bias_ld_q, bias_ld_d;
    logic [15:0]   idx_q, idx_d;
    logic [15:0]   result_q, result_d;
    logic          valid_q, valid_d;
    logic          bias_issue;

    // Next-state and registered-output logic of the sequencer FSM
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        rd_en_d    = 1'b0;
        clr_d      = 1'b0;
        result_d   = result_q;
        bias_issue = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLR;
                    clr_d   = 1'b1;
                    k_d     = '0;
                end
            end
            CLR: begin
                state_d = STREAM;
                rd_en_d = 1'b1;
                k_d     = '0;
            end
            STREAM: begin
`ifdef NEURON_BIAS_EN
                // One extra STREAM cycle with no read issues the bias load
                if (k_q == K_BIAS) begin
                    bias_issue = 1'b1;
                    state_d    = DRAIN;
                    k_d        = '0;
                end else begin
                    k_d     = k_q + 1'b1;
                    rd_en_d = (k_q != K_LAST);
                end
`else
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    k_d     = k_q + 1'b1;
                    rd_en_d = 1'b1;
                end
`endif
            end
            DRAIN: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d  = OUT;
                result_d = dp_res;
            end
            OUT: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == OUT);

        // Load pipeline: read data returns one cycle after rd_en, so the
        // load strobe and index trail the read request by one cycle
        ld_d      = rd_en_q | bias_issue;
        bias_ld_d = bias_issue;
        idx_d     = ld_d ? 16'(k_q) : '0;
    end

    // State register for the FSM, address counter and load pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            clr_q     <= 1'b0;
            ld_q      <= 1'b0;
            bias_ld_q <= 1'b0;
            idx_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            clr_q     <= clr_d;
            ld_q      <= ld_d;
            bias_ld_q <= bias_ld_d;
            idx_q     <= idx_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

`ifdef NEURON_BIAS_EN
    // Operand bytes to the datapath: memory data or the +1 x bias pair
    always_comb begin
        dp_in = '0;
        dp_w  = '0;
        if (ld_q) begin
            if (bias_ld_q) begin
                dp_in = 8'h01;
                dp_w  = bias_w;
            end else begin
                dp_in = rd_in;
                dp_w  = rd_w;
            end
        end
    end
`else
    logic unused_bias;
    assign unused_bias = ^{bias_w, bias_ld_q};

    // Operand bytes to the datapath: memory data only while loading
    always_comb begin
        dp_in = '0;
        dp_w  = '0;
        if (ld_q) begin
            dp_in = rd_in;
            dp_w  = rd_w;
        end
    end
`endif

    assign busy         = busy_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = k_q;
    assign dp_clr       = clr_q;
    assign dp_ld        = ld_q;
    assign dp_idx       = idx_q;
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule
